// File: rtl/alu_pkg.sv
// Shared constants for the 8-bit ALU: data width and operation encodings.
package alu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 4;

  // Operation select encodings; 4'hE and 4'hF are reserved.
  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_MUL  = 4'h2,
    OP_DIV  = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_XOR  = 4'h6,
    OP_NOR  = 4'h7,
    OP_NAND = 4'h8,
    OP_XNOR = 4'h9,
    OP_SHL1 = 4'hA,
    OP_SHR1 = 4'hB,
    OP_ROL1 = 4'hC,
    OP_ROR1 = 4'hD,
    OP_RSVE = 4'hE,
    OP_RSVF = 4'hF
  } op_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath: result, carry/borrow/shift-out and
// overflow/error flag for the current operands and operation.
module alu_core
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [OP_W-1:0]   i_op,
  output logic [DATA_W-1:0] o_result,
  output logic              o_carry,
  output logic              o_overflow
);

  logic [DATA_W:0]     w_sum;
  logic [DATA_W:0]     w_diff;
  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0]   w_quot;
  logic                w_div_zero;

  // Arithmetic kept one bit wider so the top bit is the carry / borrow.
  assign w_sum      = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff     = {1'b0, i_a} - {1'b0, i_b};
  assign w_prod     = (2*DATA_W)'(i_a) * (2*DATA_W)'(i_b);
  assign w_div_zero = (i_b == '0);
  // Guard the divider so a zero divisor never reaches the '/' operator.
  assign w_quot     = w_div_zero ? '1 : (i_a / i_b);

  // Select result and flags for the requested operation.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // it unassigned; an unassigned path in always_comb infers a latch.
    o_result   = '0;
    o_carry    = 1'b0;
    o_overflow = 1'b0;
    case (op_e'(i_op))
      OP_ADD: begin
        o_result   = w_sum[DATA_W-1:0];
        o_carry    = w_sum[DATA_W];
        o_overflow = (i_a[DATA_W-1] == i_b[DATA_W-1]) &&
                     (w_sum[DATA_W-1] != i_a[DATA_W-1]);
      end
      OP_SUB: begin
        o_result   = w_diff[DATA_W-1:0];
        o_carry    = w_diff[DATA_W];  // borrow: set iff i_a < i_b
        o_overflow = (i_a[DATA_W-1] != i_b[DATA_W-1]) &&
                     (w_diff[DATA_W-1] != i_a[DATA_W-1]);
      end
      OP_MUL: begin
        o_result   = w_prod[DATA_W-1:0];
        o_carry    = |w_prod[2*DATA_W-1:DATA_W];
        o_overflow = |w_prod[2*DATA_W-1:DATA_W];
      end
      OP_DIV: begin
        o_result   = w_quot;
        o_overflow = w_div_zero;
      end
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_NOR:  o_result = ~(i_a | i_b);
      OP_NAND: o_result = ~(i_a & i_b);
      OP_XNOR: o_result = ~(i_a ^ i_b);
      OP_SHL1: begin
        o_result = {i_a[DATA_W-2:0], 1'b0};
        o_carry  = i_a[DATA_W-1];
      end
      OP_SHR1: begin
        o_result = {1'b0, i_a[DATA_W-1:1]};
        o_carry  = i_a[0];
      end
      OP_ROL1: begin
        o_result = {i_a[DATA_W-2:0], i_a[DATA_W-1]};
        o_carry  = i_a[DATA_W-1];
      end
      OP_ROR1: begin
        o_result = {i_a[0], i_a[DATA_W-1:1]};
        o_carry  = i_a[0];
      end
      default: ;  // reserved encodings keep the all-zero defaults
    endcase
  end

endmodule

// File: rtl/alu.sv
// 8-bit ALU top: combinational core followed by one output register stage
// with asynchronous active-low reset. Latency is exactly one clock.
module alu
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in1,
  input  logic [DATA_W-1:0] in2,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] out,
  output logic              carryout,
  output logic              overflow
);

  logic [DATA_W-1:0] w_result;
  logic              w_carry;
  logic              w_overflow;

  logic [DATA_W-1:0] r_out;
  logic              r_carry;
  logic              r_overflow;

  alu_core u_core (
    .i_a        (in1),
    .i_b        (in2),
    .i_op       (op),
    .o_result   (w_result),
    .o_carry    (w_carry),
    .o_overflow (w_overflow)
  );

  // Capture the core result every rising edge; reset clears without a clock.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out      <= '0;
      r_carry    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments in clocked blocks so every register
      // samples pre-edge values, independent of statement order.
      r_out      <= w_result;
      r_carry    <= w_carry;
      r_overflow <= w_overflow;
    end
  end

  assign out      = r_out;
  assign carryout = r_carry;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the 8-bit ALU. Expected values are
// hand-computed constants; results are packed as {carryout, overflow, out}.
module tb_alu;
  import alu_pkg::*;

  logic       clk;
  logic       rst;
  logic [7:0] in1;
  logic [7:0] in2;
  logic [3:0] op;
  logic [7:0] out;
  logic       carryout;
  logic       overflow;

  int n_checks = 0;
  int n_fail   = 0;

  alu dut (
    .clk      (clk),
    .rst      (rst),
    .in1      (in1),
    .in2      (in2),
    .op       (op),
    .out      (out),
    .carryout (carryout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got {c,v,out}=%b_%b_%h expected %b_%b_%h",
               tag, obs[9], obs[8], obs[7:0], exp[9], exp[8], exp[7:0]);
    end
  endtask

  // Drive a vector between edges, let one rising edge register it, then check.
  task automatic vec(input string tag, input logic [3:0] o, input logic [7:0] a,
                     input logic [7:0] b, input logic [7:0] eo, input logic ec,
                     input logic ev);
    @(negedge clk);
    op  = o;
    in1 = a;
    in2 = b;
    @(posedge clk);
    #1;
    check(tag, {carryout, overflow, out}, {ec, ev, eo});
  endtask

  initial begin
    rst = 1'b0;
    in1 = 8'd25;
    in2 = 8'd18;
    op  = OP_ADD;

    // Outputs stay zero through clock edges while reset is held.
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", {carryout, overflow, out}, 10'h000);
    @(negedge clk);
    rst = 1'b1;

    // Basic arithmetic with 25 / 18.
    vec("add_25_18", OP_ADD, 8'd25, 8'd18, 8'd43, 1'b0, 1'b0);
    vec("sub_25_18", OP_SUB, 8'd25, 8'd18, 8'd7,  1'b0, 1'b0);
    vec("mul_25_18", OP_MUL, 8'd25, 8'd18, 8'hC2, 1'b1, 1'b1);
    vec("div_25_18", OP_DIV, 8'd25, 8'd18, 8'd1,  1'b0, 1'b0);

    // Bitwise with 25 / 18.
    vec("and",  OP_AND,  8'd25, 8'd18, 8'h10, 1'b0, 1'b0);
    vec("or",   OP_OR,   8'd25, 8'd18, 8'h1B, 1'b0, 1'b0);
    vec("xor",  OP_XOR,  8'd25, 8'd18, 8'h0B, 1'b0, 1'b0);
    vec("nor",  OP_NOR,  8'd25, 8'd18, 8'hE4, 1'b0, 1'b0);
    vec("nand", OP_NAND, 8'd25, 8'd18, 8'hEF, 1'b0, 1'b0);
    vec("xnor", OP_XNOR, 8'd25, 8'd18, 8'hF4, 1'b0, 1'b0);

    // Shifts and rotates on 25; in2 must be ignored.
    vec("shl1_25", OP_SHL1, 8'd25, 8'd18, 8'h32, 1'b0, 1'b0);
    vec("shr1_25", OP_SHR1, 8'd25, 8'd18, 8'h0C, 1'b1, 1'b0);
    vec("rol1_25", OP_ROL1, 8'd25, 8'd18, 8'h32, 1'b0, 1'b0);
    vec("ror1_25", OP_ROR1, 8'd25, 8'd18, 8'h8C, 1'b1, 1'b0);
    vec("shl1_81", OP_SHL1, 8'h81, 8'hFF, 8'h02, 1'b1, 1'b0);
    vec("shr1_81", OP_SHR1, 8'h81, 8'hFF, 8'h40, 1'b1, 1'b0);
    vec("rol1_81", OP_ROL1, 8'h81, 8'hFF, 8'h03, 1'b1, 1'b0);
    vec("ror1_81", OP_ROR1, 8'h81, 8'hFF, 8'hC0, 1'b1, 1'b0);

    // Reserved encodings.
    vec("rsv_e", OP_RSVE, 8'd25, 8'd18, 8'h00, 1'b0, 1'b0);
    vec("rsv_f", OP_RSVF, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0);

    // Arithmetic edge cases.
    vec("add_200_100",  OP_ADD, 8'd200, 8'd100, 8'h2C, 1'b1, 1'b0);
    vec("add_127_1",    OP_ADD, 8'd127, 8'd1,   8'h80, 1'b0, 1'b1);
    vec("sub_80_1",     OP_SUB, 8'h80,  8'd1,   8'h7F, 1'b0, 1'b1);
    vec("sub_5_6",      OP_SUB, 8'd5,   8'd6,   8'hFF, 1'b1, 1'b0);
    vec("sub_7f_80",    OP_SUB, 8'h7F,  8'h80,  8'hFF, 1'b1, 1'b1);
    vec("mul_15_17",    OP_MUL, 8'd15,  8'd17,  8'hFF, 1'b0, 1'b0);
    vec("div_25_0",     OP_DIV, 8'd25,  8'd0,   8'hFF, 1'b0, 1'b1);
    vec("div_255_16",   OP_DIV, 8'd255, 8'd16,  8'd15, 1'b0, 1'b0);

    // Latency: a change between edges is not visible until the next edge.
    vec("lat_base", OP_SUB, 8'd25, 8'd18, 8'd7, 1'b0, 1'b0);
    @(negedge clk);
    op  = OP_XOR;
    in1 = 8'hF0;
    #1;
    check("lat_hold", {carryout, overflow, out}, {1'b0, 1'b0, 8'd7});
    @(posedge clk);
    #1;
    check("lat_next", {carryout, overflow, out}, {1'b0, 1'b0, 8'hE2});

    // Async reset between edges clears immediately, no clock needed.
    vec("pre_rst", OP_MUL, 8'd25, 8'd18, 8'hC2, 1'b1, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("rst_async", {carryout, overflow, out}, 10'h000);
    @(posedge clk);
    #1;
    check("rst_held", {carryout, overflow, out}, 10'h000);
    @(negedge clk);
    rst = 1'b1;
    vec("post_rst", OP_ADD, 8'd127, 8'd1, 8'h80, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
